// File: rtl/prio_arb4_if.sv
// Request/grant bundle between requesters (master) and the 4-way arbiter (slave).
interface prio_arb4_if;
   logic [3:0] req;
   logic       rr_mode;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_v;
   logic       expired;

   modport master (
      output req, rr_mode,
      input  gnt, gnt_id, gnt_v, expired
   );

   modport slave (
      input  req, rr_mode,
      output gnt, gnt_id, gnt_v, expired
   );
endinterface

// File: rtl/prio_arb4.sv
// Four-requester arbiter: fixed or round-robin priority, registered one-hot grant,
// hold limit with an expiry pulse, and a mandatory idle gap between grants.
module prio_arb4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic         clk,
   input logic         rst_n,
   prio_arb4_if.slave  bus
);

   localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       gnt_v_q, gnt_v_d;
   logic       expired_q, expired_d;
   logic [7:0] hold_q, hold_d;
   logic [1:0] last_id_q, last_id_d;

   logic [1:0] win_fp, win_rr, win, rr_start, rr_idx;
   logic       rr_found;

   // Fixed: last set bit in ascending scan is the highest index.
   always_comb begin
      win_fp = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bus.req[i]) win_fp = i[1:0];
      end
   end

   // Round-robin: scan downward from last_id-1 with wrap, so last owner is checked last.
   always_comb begin
      win_rr   = '0;
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_start = last_id_q - 2'd1;
      for (int unsigned k = 0; k < 4; k++) begin
         rr_idx = rr_start - k[1:0];
         if (bus.req[rr_idx] && !rr_found) begin
            win_rr   = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   assign win = bus.rr_mode ? win_rr : win_fp;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_v_d   = gnt_v_q;
      expired_d = 1'b0;
      hold_d    = hold_q;
      last_id_d = last_id_q;
      unique case (state_q)
         IDLE: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            gnt_v_d  = 1'b0;
            if (bus.req != 4'b0000) begin
               state_d   = GRANT;
               gnt_d     = 4'b0001 << win;
               gnt_id_d  = win;
               gnt_v_d   = 1'b1;
               hold_d    = 8'd1;
               last_id_d = win;
            end
         end
         GRANT: begin
            // Voluntary release has priority over the hold limit.
            if (!bus.req[gnt_id_q]) begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               gnt_v_d  = 1'b0;
               hold_d   = '0;
            end else if (hold_q == MaxHold) begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_id_d  = '0;
               gnt_v_d   = 1'b0;
               hold_d    = '0;
               expired_d = 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         gnt_v_q   <= 1'b0;
         expired_q <= 1'b0;
         hold_q    <= '0;
         last_id_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_v_q   <= gnt_v_d;
         expired_q <= expired_d;
         hold_q    <= hold_d;
         last_id_q <= last_id_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.gnt_v   = gnt_v_q;
   assign bus.expired = expired_q;

endmodule

// File: tb/tb_prio_arb4.sv
// Directed bench for prio_arb4: three instances (hold limits 8, 2, 1) share one stimulus.
module tb_prio_arb4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic       rr = 1'b0;
   int         total = 0;
   int         bad = 0;

   prio_arb4_if if8 ();
   prio_arb4_if if2 ();
   prio_arb4_if if1 ();

   assign if8.req = req;  assign if8.rr_mode = rr;
   assign if2.req = req;  assign if2.rr_mode = rr;
   assign if1.req = req;  assign if1.rr_mode = rr;

   prio_arb4 #(.MAX_HOLD(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   prio_arb4 #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   prio_arb4 #(.MAX_HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Structural invariants on every instance, sampled mid-cycle.
   always @(negedge clk) begin
      total++;
      assert ($onehot0(if8.gnt) && $onehot0(if2.gnt) && $onehot0(if1.gnt)
              && (if8.gnt_v === |if8.gnt) && (if2.gnt_v === |if2.gnt)
              && (if1.gnt_v === |if1.gnt)) else begin
         bad++;
         $error("FAIL onehot observed=%b/%b/%b", if8.gnt, if2.gnt, if1.gnt);
      end
   end

   initial begin
      int ids[5];
      ids = '{3, 2, 1, 0, 3};

      // Reset state
      tick();
      chk("rst_gnt", if8.gnt, 4'b0000);
      chk("rst_gnt_v", {3'b000, if8.gnt_v}, 4'd0);
      chk("rst_gnt_id", {2'b00, if8.gnt_id}, 4'd0);
      chk("rst_expired", {3'b000, if8.expired}, 4'd0);
      rst_n = 1'b1;

      // Idle: no request for 10 cycles
      req = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_gnt_v", {3'b000, if8.gnt_v}, 4'd0);
         chk("idle_expired", {3'b000, if8.expired}, 4'd0);
      end

      // Fixed priority, 1001 held, hold limit 8
      req = 4'b1001;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("fp_hold_gnt", if8.gnt, 4'b1000);
         chk("fp_hold_exp", {3'b000, if8.expired}, 4'd0);
      end
      tick();
      chk("fp_expire_gnt", if8.gnt, 4'b0000);
      chk("fp_expire_pulse", {3'b000, if8.expired}, 4'd1);
      tick();
      chk("fp_regrant", if8.gnt, 4'b1000);
      chk("fp_regrant_exp", {3'b000, if8.expired}, 4'd0);
      req = 4'b0000;
      tick();
      chk("fp_release", if8.gnt, 4'b0000);
      tick();

      // Round-robin, 1111 held, hold limit 2
      do_reset();
      rr = 1'b1;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         chk("rr_gnt_a", if2.gnt, 4'(4'b0001 << ids[g]));
         chk("rr_id_a", {2'b00, if2.gnt_id}, 4'(ids[g]));
         tick();
         chk("rr_gnt_b", if2.gnt, 4'(4'b0001 << ids[g]));
         tick();
         chk("rr_gap_gnt", if2.gnt, 4'b0000);
         chk("rr_gap_exp", {3'b000, if2.expired}, 4'd1);
      end
      req = 4'b0000;
      rr = 1'b0;
      tick();
      tick();

      // Hold limit 1: single-cycle grant then expiry
      do_reset();
      req = 4'b0010;
      tick();
      chk("h1_gnt", if1.gnt, 4'b0010);
      tick();
      chk("h1_gap", if1.gnt, 4'b0000);
      chk("h1_exp", {3'b000, if1.expired}, 4'd1);
      tick();
      chk("h1_regrant", if1.gnt, 4'b0010);
      req = 4'b0000;
      tick();
      tick();

      // Owner drops on the cycle the counter reaches the limit: voluntary
      do_reset();
      req = 4'b0001;
      tick();
      chk("vl_gnt1", if2.gnt, 4'b0001);
      tick();
      chk("vl_gnt2", if2.gnt, 4'b0001);
      req = 4'b0000;
      tick();
      chk("vl_rel_gnt", if2.gnt, 4'b0000);
      chk("vl_rel_exp", {3'b000, if2.expired}, 4'd0);
      tick();

      // Voluntary release with 0011 pending, fixed mode
      req = 4'b0111;
      tick();
      chk("vr_c1", if8.gnt, 4'b0100);
      tick();
      tick();
      chk("vr_c3", if8.gnt, 4'b0100);
      req = 4'b0011;
      tick();
      chk("vr_idle_gnt", if8.gnt, 4'b0000);
      chk("vr_idle_exp", {3'b000, if8.expired}, 4'd0);
      tick();
      chk("vr_next", if8.gnt, 4'b0010);
      req = 4'b0000;
      tick();
      tick();

      // Pre-emption attempt and mid-grant rr_mode change are both ignored
      do_reset();
      req = 4'b0001;
      tick();
      chk("pe_c1", if8.gnt, 4'b0001);
      tick();
      req = 4'b1001;
      rr = 1'b1;
      for (int i = 3; i <= 8; i++) begin
         tick();
         chk("pe_hold", if8.gnt, 4'b0001);
      end
      rr = 1'b0;
      tick();
      chk("pe_exp_gnt", if8.gnt, 4'b0000);
      chk("pe_exp", {3'b000, if8.expired}, 4'd1);
      tick();
      chk("pe_next", if8.gnt, 4'b1000);
      req = 4'b0000;
      tick();
      tick();

      // Asynchronous reset mid-grant, then round-robin restart
      req = 4'b0100;
      tick();
      chk("ar_gnt", if8.gnt, 4'b0100);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_async_gnt", if8.gnt, 4'b0000);
      chk("ar_async_v", {3'b000, if8.gnt_v}, 4'd0);
      chk("ar_async_id", {2'b00, if8.gnt_id}, 4'd0);
      rr = 1'b1;
      req = 4'b0101;
      tick();
      chk("ar_held", if8.gnt, 4'b0000);
      rst_n = 1'b1;
      tick();
      chk("ar_first_rr", if8.gnt, 4'b0100);
      chk("ar_first_rr_id", {2'b00, if8.gnt_id}, 4'd2);
      req = 4'b0000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prio_arb4.md
PRIO_ARB4 -- requirements
Module: prio_arb4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  4  request vector; req[i] high = requester i wants the shared resource.
REQ-005 rr_mode  input  1  0 = fixed priority (req[3] highest, req[0] lowest); 1 = round-robin.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant is active.
REQ-007 gnt_id  output  2  index of the granted requester, registered; 0 when gnt_v = 0.
REQ-008 gnt_v  output  1  high while any grant is active; equals OR of gnt.
REQ-009 expired  output  1  single-cycle pulse marking a grant forcibly ended by the hold limit.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and GRANT, with all outputs driven from registers.
REQ-011 In IDLE, gnt = 0, gnt_v = 0 and gnt_id = 0.
REQ-012 In IDLE with req != 0 at a rising edge, the FSM SHALL enter GRANT with gnt/gnt_id/gnt_v set to the arbitration winner, so a grant appears one cycle after the request is sampled.
REQ-013 In IDLE with req == 0, the FSM SHALL stay in IDLE.
REQ-014 Fixed-priority winner (rr_mode = 0): highest set index of req.
REQ-015 Round-robin winner (rr_mode = 1): first set bit searching downward, with wrap, from index (last_id - 1) mod 4; the last owner is searched last.
REQ-016 last_id SHALL be a register updated to the winner on every IDLE->GRANT transition.
REQ-017 rr_mode SHALL be sampled only at arbitration, and a change during GRANT SHALL not affect the current grant.
REQ-018 A hold counter SHALL load 1 on entry to GRANT and increment each cycle the FSM remains in GRANT.
REQ-019 In GRANT, if req[gnt_id] is 0 at a rising edge, the FSM SHALL return to IDLE with gnt cleared and expired = 0.
REQ-020 In GRANT, if req[gnt_id] is 1 and the hold counter equals MAX_HOLD, the FSM SHALL return to IDLE with gnt cleared and expired pulsed high for that one IDLE cycle.
REQ-021 Otherwise the FSM SHALL remain in GRANT with gnt unchanged.
REQ-022 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration.
REQ-023 Every grant SHALL be separated by at least one IDLE cycle with gnt = 0, and gnt SHALL never have more than one bit set.
REQ-024 With MAX_HOLD = 1 and the owner still requesting, the grant SHALL last exactly one cycle and expired SHALL pulse.
REQ-025 If the owner drops req in the same cycle the counter reaches MAX_HOLD, the release SHALL be treated as voluntary (expired = 0).

Reset
REQ-026 On rst_n low, the following SHALL be forced immediately, independent of clk: state = IDLE, gnt = 0, gnt_id = 0, gnt_v = 0, expired = 0, hold counter = 0, last_id = 0.
REQ-027 Reset asserted during GRANT SHALL drop gnt without waiting for a clock edge.
REQ-028 The first arbitration after reset in round-robin mode SHALL search 3,2,1,0 (identical to fixed priority).
REQ-029 Reset deassertion SHALL take effect at the next rising edge, and no grant SHALL issue at the deasserting edge.

Verification
REQ-030 Fixed priority, req = 4'b1001 held, MAX_HOLD = 8 -> gnt = 4'b1000 one cycle after sampling, held 8 cycles, then expired = 1 with gnt = 0, then gnt = 4'b1000 again.
REQ-031 Round-robin, req = 4'b1111 held, MAX_HOLD = 2 -> grant order id 3,2,1,0,3, each grant 2 cycles, each followed by a 1-cycle gap with expired = 1.
REQ-032 Voluntary release: owner 2 drops req[2] on its third grant cycle with req = 4'b0011 pending -> one IDLE cycle, expired = 0, then gnt = 4'b0010 (fixed mode).
REQ-033 Pre-emption attempt: owner 0 granted, req[3] rises mid-grant -> gnt stays 4'b0001 until owner 0 releases or expires.
REQ-034 Reset mid-grant: rst_n low while gnt = 4'b0100 -> gnt, gnt_v, gnt_id = 0 before the next clk edge; after release with req = 4'b0101 in round-robin mode, the first grant = 4'b0100.
REQ-035 Idle check: req = 0 for 10 cycles -> gnt_v = 0 and expired = 0 throughout; a one-hot assertion on gnt SHALL pass in all scenarios.
